// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and default constants for the external SRAM
// controller slice.
//   state_t     - controller states (IDLE, LO, HI, DONE)
//   op_t        - latched access kind (RD, WR)
//   DEF_*       - default parameter values
//   word_offset - word offset of a byte address relative to a base address
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   typedef enum logic {
      RD,
      WR
   } op_t;

   localparam int unsigned DEF_WAIT_CYCLES = 1;
   localparam int unsigned DEF_SRAM_ADDR_W = 18;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

   // Word offset from base, modulo 2^32. Byte offset bits of addr are ignored.
   function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
      return ({addr[31:2], 2'b00} - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request bus plus external SRAM pad signals.
//   wr_en, rd_en, addr, wdata : pipeline request
//   rdata, ready              : pipeline response (ready low = freeze)
//   sram_addr, sram_dq_out, sram_dq_oe, sram_we_n : pad outputs
//   sram_dq_in                : pad read data
// Modports: master = pipeline/pad side, slave = controller.
interface sram_controller_if #(
   parameter int unsigned SRAM_ADDR_W = 18
);

   logic                   wr_en;
   logic                   rd_en;
   logic [31:0]            addr;
   logic [31:0]            wdata;
   logic [31:0]            rdata;
   logic                   ready;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic [15:0]            sram_dq_out;
   logic                   sram_dq_oe;
   logic [15:0]            sram_dq_in;
   logic                   sram_we_n;

   modport master (
      output wr_en, rd_en, addr, wdata, sram_dq_in,
      input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata, sram_dq_in,
      output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

endinterface

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: per-phase cycle counter shared by the LO and HI phases.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the count (asserted on the edge entering a phase)
//   last      : current cycle is the final cycle of the phase
//   last_next : the cycle after the coming edge will be the final one
module sram_phase_timer
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic last,
   output logic last_next
);

   localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (!last) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign last = (cnt == CW'(WAIT_CYCLES));

   // Lets the controller register pad strobes one cycle ahead so they are
   // aligned with the phase cycle they belong to.
   assign last_next = !clr && (last || (cnt == CW'(WAIT_CYCLES - 1)));

endmodule

// File: rtl/sram_controller.sv
// sram_controller: multi-cycle 32-bit word access to a 16-bit external SRAM.
// Each request is split into a low-halfword (LO) and high-halfword (HI)
// phase of WAIT_CYCLES+1 cycles each, followed by one DONE cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sram_controller_if (request, response, pads)
// All pad outputs and rdata are registered; ready is combinational.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   bus
);

   localparam int unsigned WW = SRAM_ADDR_W - 1;

   state_t                 state;
   state_t                 state_n;
   op_t                    op;
   op_t                    op_n;
   logic [WW-1:0]          word;
   logic [WW-1:0]          word_n;
   logic [31:0]            wdata_q;
   logic [31:0]            wdata_n;
   logic                   req;
   logic                   accept;
   logic                   clr;
   logic                   last;
   logic                   last_next;

   logic [SRAM_ADDR_W-1:0] sram_addr_n;
   logic [15:0]            sram_dq_out_n;
   logic                   sram_dq_oe_n;
   logic                   sram_we_n_n;

   assign req    = bus.wr_en | bus.rd_en;
   assign accept = (state == IDLE) && req;

   sram_phase_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .last      (last),
      .last_next (last_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      bus.ready = 1'b0;
      case (state)
         IDLE: begin
            bus.ready = !req;
            if (req) state_n = LO;
         end
         LO:   if (last) state_n = HI;
         HI:   if (last) state_n = DONE;
         DONE: begin
            bus.ready = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Counter restarts on every phase entry and idles at zero outside phases.
      clr = (state_n != state) || !((state == LO) || (state == HI));
   end

   // Request capture
   always_comb begin
      op_n    = op;
      word_n  = word;
      wdata_n = wdata_q;
      if (accept) begin
         op_n    = bus.wr_en ? WR : RD;
         word_n  = WW'(word_offset(bus.addr, BASE_ADDR));
         wdata_n = bus.wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op      <= RD;
         word    <= '0;
         wdata_q <= '0;
      end else begin
         op      <= op_n;
         word    <= word_n;
         wdata_q <= wdata_n;
      end
   end

   // Pad outputs are computed from the post-edge state so the registered
   // values line up with the phase they describe without a cycle of lag.
   always_comb begin
      sram_addr_n   = bus.sram_addr;
      sram_dq_out_n = bus.sram_dq_out;
      sram_dq_oe_n  = 1'b0;
      sram_we_n_n   = 1'b1;
      if ((state_n == LO) || (state_n == HI)) begin
         sram_addr_n = {word_n, (state_n == HI)};
         if (op_n == WR) begin
            sram_dq_oe_n  = 1'b1;
            sram_dq_out_n = (state_n == HI) ? wdata_n[31:16] : wdata_n[15:0];
            // Strobe released in the final phase cycle: rising edge with
            // address and data still held.
            sram_we_n_n   = last_next;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sram_addr   <= '0;
         bus.sram_dq_out <= '0;
         bus.sram_dq_oe  <= 1'b0;
         bus.sram_we_n   <= 1'b1;
      end else begin
         bus.sram_addr   <= sram_addr_n;
         bus.sram_dq_out <= sram_dq_out_n;
         bus.sram_dq_oe  <= sram_dq_oe_n;
         bus.sram_we_n   <= sram_we_n_n;
      end
   end

   // Read data sampled on the edge closing the final cycle of each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rdata <= '0;
      end else if (last && (op == RD)) begin
         if (state == LO) bus.rdata[15:0]  <= bus.sram_dq_in;
         if (state == HI) bus.rdata[31:16] <= bus.sram_dq_in;
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Two instances: default timing and WAIT_CYCLES=3. Requests go to the
   // instance chosen by sel; observations are muxed the same way.
   sram_controller_if #(.SRAM_ADDR_W(18)) b1 ();
   sram_controller_if #(.SRAM_ADDR_W(18)) b3 ();

   sram_controller #(.WAIT_CYCLES(1), .SRAM_ADDR_W(18), .BASE_ADDR(32'd1024))
      dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   sram_controller #(.WAIT_CYCLES(3), .SRAM_ADDR_W(18), .BASE_ADDR(32'd1024))
      dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

   logic        sel = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   assign b1.wr_en = wr_en & ~sel;
   assign b1.rd_en = rd_en & ~sel;
   assign b1.addr  = addr;
   assign b1.wdata = wdata;
   assign b3.wr_en = wr_en & sel;
   assign b3.rd_en = rd_en & sel;
   assign b3.addr  = addr;
   assign b3.wdata = wdata;

   // External SRAM models: asynchronous read, write on rising edge of we_n.
   logic [15:0] mem0 [0:1023];
   logic [15:0] mem1 [0:1023];
   assign b1.sram_dq_in = mem0[b1.sram_addr[9:0]];
   assign b3.sram_dq_in = mem1[b3.sram_addr[9:0]];
   always @(posedge b1.sram_we_n) if (rst === 1'b0 && b1.sram_dq_oe === 1'b1) mem0[b1.sram_addr[9:0]] = b1.sram_dq_out;
   always @(posedge b3.sram_we_n) if (rst === 1'b0 && b3.sram_dq_oe === 1'b1) mem1[b3.sram_addr[9:0]] = b3.sram_dq_out;

   logic        ready_m, we_n_m, oe_m;
   logic [31:0] rdata_m;
   logic [17:0] saddr_m;
   logic [15:0] dqo_m;
   assign ready_m = sel ? b3.ready       : b1.ready;
   assign we_n_m  = sel ? b3.sram_we_n   : b1.sram_we_n;
   assign oe_m    = sel ? b3.sram_dq_oe  : b1.sram_dq_oe;
   assign rdata_m = sel ? b3.rdata       : b1.rdata;
   assign saddr_m = sel ? b3.sram_addr   : b1.sram_addr;
   assign dqo_m   = sel ? b3.sram_dq_out : b1.sram_dq_out;

   // Reference: word-level memory keyed by instance and word index.
   logic [31:0] ref_words [int];
   logic [31:0] exp_rd [2];

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] a);
      logic [31:0] w;
      w = ((a & 32'hFFFF_FFFC) - 32'd1024) >> 2;
      return int'(w);
   endfunction

   function automatic logic [15:0] mem_rd(input int i);
      return sel ? mem1[i] : mem0[i];
   endfunction

   function automatic logic [31:0] ref_get(input int key);
      return ref_words.exists(key) ? ref_words[key] : 32'h0;
   endfunction

   // One access: request at a negedge, held for the first cycle only.
   task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      int unsigned wc;
      int unsigned n;
      int unsigned we_lo;
      int unsigned oe_hi;
      int          wi;
      int          key;
      bit          got;
      wc = sel ? 3 : 1;
      wi = word_of(a);
      key = (sel ? 65536 : 0) + wi;
      @(negedge clk);
      wr_en = w; rd_en = r; addr = a; wdata = d;
      #1 check("ready_low_on_request", {31'b0, ready_m}, 32'd0);
      n = 0; we_lo = 0; oe_hi = 0; got = 0;
      while (n < 40 && !got) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         wr_en = 1'b0; rd_en = 1'b0;
         #1;
         if (ready_m === 1'b1) got = 1;
         else begin
            if (we_n_m === 1'b0) we_lo++;
            if (oe_m === 1'b1) oe_hi++;
         end
      end
      check("latency", n, 2 * (wc + 1) + 1);
      check("we_n_low_cycles", we_lo, w ? 2 * wc : 0);
      check("oe_cycles", oe_hi, w ? 2 * (wc + 1) : 0);
      if (w) ref_words[key] = d;
      else   exp_rd[sel] = ref_get(key);
      check("rdata", rdata_m, exp_rd[sel]);
      if (w) begin
         check("sram_lo_half", {16'b0, mem_rd(2 * wi)},     {16'b0, d[15:0]});
         check("sram_hi_half", {16'b0, mem_rd(2 * wi + 1)}, {16'b0, d[31:16]});
      end
   endtask

   initial begin
      logic        rw;
      logic [31:0] ra;
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      exp_rd[0] = '0;
      exp_rd[1] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_ready",    {31'b0, ready_m}, 32'd1);
         check("rst_we_n",     {31'b0, we_n_m},  32'd1);
         check("rst_oe",       {31'b0, oe_m},    32'd0);
         check("rst_rdata",    rdata_m,          32'd0);
         check("rst_sram_addr", {14'b0, saddr_m}, 32'd0);
         check("rst_dq_out",   {16'b0, dqo_m},   32'd0);
      end
      sel = 1'b0;

      // Directed write / unaligned read-back / simultaneous request
      access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
      access(1'b0, 1'b1, 32'd1031, 32'h0);
      check("readback_value", rdata_m, 32'hDEADBEEF);
      access(1'b1, 1'b1, 32'd1024, 32'h12345678);
      check("both_rdata_unchanged", rdata_m, 32'hDEADBEEF);

      // Randomized traffic
      for (int i = 0; i < 16; i++) begin
         rw = 1'($urandom_range(0, 1));
         ra = 32'd1024 + 4 * $urandom_range(0, 400) + $urandom_range(0, 3);
         access(rw, rw ? 1'($urandom_range(0, 1)) : 1'b1, ra, $urandom);
      end

      // Reset during the HI phase of a write to word 1
      access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
      @(negedge clk);
      wr_en = 1'b1; addr = 32'd1028; wdata = 32'hCAFEF00D;
      @(posedge clk); @(negedge clk);
      wr_en = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("hi_phase_we_low", {31'b0, we_n_m}, 32'd0);
      rst = 1'b1;
      #1;
      check("midrst_we_n",  {31'b0, we_n_m},  32'd1);
      check("midrst_oe",    {31'b0, oe_m},    32'd0);
      check("midrst_ready", {31'b0, ready_m}, 32'd1);
      check("midrst_rdata", rdata_m,          32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_addr2", {16'b0, mem0[2]}, 32'h0000F00D);
      check("midrst_addr3", {16'b0, mem0[3]}, 32'h0000DEAD);
      ref_words[1] = 32'hDEADF00D;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      access(1'b0, 1'b1, 32'd1028, 32'h0);
      check("after_rst_read", rdata_m, 32'hDEADF00D);

      // WAIT_CYCLES=3 instance: a few writes then back-to-back reads
      sel = 1'b1;
      for (int i = 0; i < 4; i++)
         access(1'b1, 1'b0, 32'd1024 + 4 * i, $urandom);
      for (int i = 0; i < 6; i++)
         access(1'b0, 1'b1, 32'd1024 + 4 * $urandom_range(0, 5), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage and a 16-bit external SRAM, replacing the single-cycle on-chip data array for the data path. It accepts one 32-bit word read or write per request, splits it into two halfword SRAM phases with programmable wait states, and drives `ready` low while busy so the pipeline freezes until the access completes.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles per halfword phase; legal values ≥ 1.
- `SRAM_ADDR_W`, default 18: SRAM halfword address width.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  MEM-stage write request.
- `rd_en`  in  1  MEM-stage read request.
- `addr`  in  32  byte address from ALU result.
- `wdata`  in  32  store data (`Val_Rm`).
- `rdata`  out  32  load data.
- `ready`  out  1  low = freeze pipeline.
- `sram_addr`  out  SRAM_ADDR_W  halfword address.
- `sram_dq_out`  out  16  write data to pad.
- `sram_dq_oe`  out  1  pad output enable.
- `sram_dq_in`  in  16  read data from pad.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: if `wr_en | rd_en`, latch op, word index, and `wdata`; go to LO. Write wins if both are asserted; the access is treated as a write and `rdata` is unchanged.
- Word index: (`{addr[31:2],2'b00}` − BASE_ADDR) >> 2, 32-bit wrap-around subtraction, truncated to SRAM_ADDR_W−1 bits.
- `sram_addr` = {word, 0} in LO and {word, 1} in HI. The low halfword (bits 15:0) is at the even address.
- Each of LO and HI lasts WAIT_CYCLES+1 cycles, counted by a phase counter that is cleared on phase entry. The phase transitions when counter == WAIT_CYCLES.
- Write phase:
  - `sram_dq_oe`=1 for the whole phase.
  - `sram_dq_out` = latched half.
  - `sram_we_n`=0 for all cycles of the phase except the last, giving a rising edge with address and data stable.
- Read phase:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `sram_dq_in` is sampled on the clock edge ending the last phase cycle, into `rdata[15:0]` (LO) or `rdata[31:16]` (HI).
- DONE: one cycle, then IDLE unconditionally. Back-to-back requests therefore have one IDLE cycle between accesses.
- `ready` (combinational) = (state==IDLE & ~(wr_en|rd_en)) | state==DONE.
- `rdata` holds its value until overwritten by the next read.
- Requests are latched at IDLE. Dropping `wr_en`/`rd_en` mid-access does not abort the access.

## Timing
- Reset values:
  - state = IDLE
  - `rdata` = 0
  - `sram_addr` = 0
  - `sram_dq_out` = 0
  - `sram_dq_oe` = 0
  - `sram_we_n` = 1
  - `ready` = 1 if no request is present.
- Reset mid-access: immediate return to IDLE. The SRAM write strobe is deasserted asynchronously, the partial write is not completed, and `rdata` is cleared.
- Latency: a request first seen in IDLE at cycle 0 gives `ready`=1 at cycle 2·(WAIT_CYCLES+1)+1, which is 5 for the default. `rdata` is valid in that same cycle.
- `ready` goes low in the same cycle a request appears in IDLE, so the pipeline freezes without a slip.
- SRAM outputs are registered. `ready` is the only combinational output.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the op encoding (RD, WR);
  - default constants for WAIT_CYCLES and BASE_ADDR.
- Sub-module `sram_phase_timer`: a WAIT_CYCLES counter with clear and `last` output, reused by both phases.

## Test plan
- Reset then idle: `rst` pulse → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0.
- Write with `addr`=1028, `wdata`=0xDEADBEEF, W=1:
  - `sram_addr`=2 carries 0xBEEF, then `sram_addr`=3 carries 0xDEAD.
  - Each phase has one `sram_we_n` low cycle.
  - `ready` rises at cycle 5.
- Read back `addr`=1031: the SRAM model returns the written halves → `rdata`=0xDEADBEEF at cycle 5; the unaligned low bits are ignored.
- `wr_en` and `rd_en` together with `addr`=1024, `wdata`=0x12345678 → write to SRAM addresses 0/1, `rdata` unchanged.
- `rst` asserted during HI of a write → immediate IDLE, `sram_we_n`=1. SRAM address 3 is unmodified and address 2 holds the new low half.
- WAIT_CYCLES=3, back-to-back reads → each phase is 4 cycles, `ready` high after 9 cycles, and one IDLE cycle separates the accesses.
